// File: rtl/al4s3b_wb_multi_counter.sv
// Wishbone-slave bank of programmable up/down counters with compare,
// reload, one-shot mode, sticky terminal flags and a masked interrupt.
module al4s3b_wb_multi_counter #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    parameter int ADDRWIDTH = 7,
    parameter int DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] ID_VALUE = 32'h0000_0C47,
    parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic                        WB_CLK,
    input  logic                        WB_RST_N,
    input  logic [ADDRWIDTH-1:0]        WBs_ADR,
    input  logic                        WBs_CYC,
    input  logic                        WBs_STB,
    input  logic                        WBs_WE,
    input  logic [3:0]                  WBs_BYTE_STB,
    input  logic [DATAWIDTH-1:0]        WBs_WR_DAT,
    output logic [DATAWIDTH-1:0]        WBs_RD_DAT,
    output logic                        WBs_ACK,
    output logic [NUM_CH*CNT_WIDTH-1:0] count,
    output logic                        irq
);

    localparam int CHW = ADDRWIDTH - 2;
    localparam logic [ADDRWIDTH-1:0] ID_ADR = '1;
    localparam logic [ADDRWIDTH-1:0] STATUS_ADR = ID_ADR - ADDRWIDTH'(1);

    function automatic logic [DATAWIDTH-1:0] byte_merge(
        input logic [DATAWIDTH-1:0] old,
        input logic [DATAWIDTH-1:0] wdat,
        input logic [3:0]           be
    );
        byte_merge = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) byte_merge[b*8 +: 8] = wdat[b*8 +: 8];
        end
    endfunction

    function automatic logic [DATAWIDTH-1:0] zext(
        input logic [CNT_WIDTH-1:0] v
    );
        zext = '0;
        zext[CNT_WIDTH-1:0] = v;
    endfunction

    logic                              ack_q;
    logic [DATAWIDTH-1:0]              rd_q;
    logic [DATAWIDTH-1:0]              rd_mux;
    logic [DATAWIDTH-1:0]              status_rd;
    logic [NUM_CH-1:0]                 status_q;
    logic [NUM_CH-1:0]                 w1c;
    logic [NUM_CH-1:0]                 term_vec;
    logic [NUM_CH-1:0]                 ie_vec;
    logic [NUM_CH-1:0]                 ch_hit;
    logic [NUM_CH-1:0][DATAWIDTH-1:0]  ch_rd;
    logic                              irq_q;
    logic                              acc;
    logic                              wr;
    logic                              id_sel;
    logic                              st_sel;
    logic [CHW-1:0]                    ch_adr;
    logic [1:0]                        reg_adr;

    // A request is taken only while ACK is low, so every access is 2 cycles.
    assign acc     = WBs_CYC & WBs_STB & ~ack_q;
    assign wr      = acc & WBs_WE;
    assign ch_adr  = WBs_ADR[ADDRWIDTH-1:2];
    assign reg_adr = WBs_ADR[1:0];
    assign id_sel  = (WBs_ADR == ID_ADR);
    assign st_sel  = (WBs_ADR == STATUS_ADR);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] load_q;
        logic [CNT_WIDTH-1:0] cmp_q;
        logic [3:0]           ctrl_q;
        logic [DATAWIDTH-1:0] ld_m;
        logic [DATAWIDTH-1:0] cmp_m;
        logic [DATAWIDTH-1:0] rd_v;
        logic                 ld_wr;
        logic                 ctrl_wr;
        logic                 cmp_wr;
        logic                 term;

        assign ch_hit[n] = (ch_adr == CHW'(n));
        assign ld_wr     = wr & ch_hit[n] & (reg_adr == 2'd1);
        assign cmp_wr    = wr & ch_hit[n] & (reg_adr == 2'd3);
        assign ctrl_wr   = wr & ch_hit[n] & (reg_adr == 2'd0)
                         & WBs_BYTE_STB[0];
        assign ld_m  = byte_merge(zext(load_q), WBs_WR_DAT, WBs_BYTE_STB);
        assign cmp_m = byte_merge(zext(cmp_q), WBs_WR_DAT, WBs_BYTE_STB);

        // A LOAD write suppresses the terminal check for this cycle.
        assign term        = ctrl_q[0] & (cnt_q == cmp_q) & ~ld_wr;
        assign term_vec[n] = term;
        assign ie_vec[n]   = ctrl_q[3];
        assign count[n*CNT_WIDTH +: CNT_WIDTH] = cnt_q;

        always_comb begin
            rd_v = '0;
            unique case (reg_adr)
                2'd0: rd_v[3:0] = ctrl_q;
                2'd1: rd_v = zext(load_q);
                2'd2: rd_v = zext(cnt_q);
                2'd3: rd_v = zext(cmp_q);
            endcase
        end
        assign ch_rd[n] = rd_v;

        always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
            if (!WB_RST_N) begin
                cnt_q  <= '0;
                load_q <= '0;
                cmp_q  <= '0;
                ctrl_q <= '0;
            end else begin
                if (ld_wr) begin
                    load_q <= ld_m[CNT_WIDTH-1:0];
                    cnt_q  <= ld_m[CNT_WIDTH-1:0];
                end else if (term) begin
                    if (ctrl_q[2]) ctrl_q[0] <= 1'b0;
                    else           cnt_q     <= load_q;
                end else if (ctrl_q[0]) begin
                    cnt_q <= ctrl_q[1] ? cnt_q - CNT_WIDTH'(1)
                                       : cnt_q + CNT_WIDTH'(1);
                end
                // Placed last so a software CTRL write beats one-shot clear.
                if (ctrl_wr) ctrl_q <= WBs_WR_DAT[3:0];
                if (cmp_wr)  cmp_q  <= cmp_m[CNT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        status_rd = '0;
        status_rd[NUM_CH-1:0] = status_q;
    end

    always_comb begin
        rd_mux = DEFAULT_READ_VALUE;
        unique case (1'b1)
            id_sel: rd_mux = ID_VALUE;
            st_sel: rd_mux = status_rd;
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_hit[n]) rd_mux = ch_rd[n];
                end
            end
        endcase
    end

    assign w1c = (wr & st_sel & WBs_BYTE_STB[0])
               ? WBs_WR_DAT[NUM_CH-1:0] : '0;

    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            ack_q    <= 1'b0;
            rd_q     <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= acc;
            rd_q     <= acc ? rd_mux : '0;
            // Terminal set is OR-ed after the clear so it wins a tie.
            status_q <= (status_q & ~w1c) | term_vec;
            irq_q    <= |(status_q & ie_vec);
        end
    end

    assign WBs_ACK    = ack_q;
    assign WBs_RD_DAT = rd_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_al4s3b_wb_multi_counter.sv
// Directed bench for al4s3b_wb_multi_counter: bus protocol, counting,
// one-shot, interrupt, status priority, byte strobes and async reset.
module tb_al4s3b_wb_multi_counter;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic              WB_CLK;
    logic              WB_RST_N;
    logic [6:0]        WBs_ADR;
    logic              WBs_CYC;
    logic              WBs_STB;
    logic              WBs_WE;
    logic [3:0]        WBs_BYTE_STB;
    logic [31:0]       WBs_WR_DAT;
    logic [31:0]       WBs_RD_DAT;
    logic              WBs_ACK;
    logic [NCH*CW-1:0] count;
    logic              irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] r;
    logic [31:0] up_seq[7];
    logic [31:0] os_seq[5];
    logic [31:0] dn_seq[3];

    al4s3b_wb_multi_counter #(
        .NUM_CH(NCH), .CNT_WIDTH(CW), .ADDRWIDTH(7), .DATAWIDTH(32),
        .ID_VALUE(32'h0000_0C47), .DEFAULT_READ_VALUE(32'hBAD_FAB_AC)
    ) dut (
        .WB_CLK(WB_CLK), .WB_RST_N(WB_RST_N), .WBs_ADR(WBs_ADR),
        .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB), .WBs_WE(WBs_WE),
        .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WR_DAT(WBs_WR_DAT),
        .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
        .count(count), .irq(irq)
    );

    initial WB_CLK = 1'b0;
    always #5 WB_CLK = ~WB_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] cnt(input int n);
        return 32'(count[n*CW +: CW]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge WB_CLK);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; returns likewise.
    task automatic xfer(input logic we, input logic [6:0] adr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd);
        int n;
        WBs_CYC = 1'b1; WBs_STB = 1'b1; WBs_WE = we;
        WBs_ADR = adr; WBs_BYTE_STB = be; WBs_WR_DAT = wd;
        n = 0;
        do begin
            @(posedge WB_CLK);
            #1;
            n++;
        end while (!WBs_ACK && n < 4);
        chk("ack_latency", 32'(n), 32'd1);
        rd = WBs_RD_DAT;
        WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0;
        @(posedge WB_CLK);
        #1;
        chk("ack_one_cycle", 32'(WBs_ACK), 32'd0);
    endtask

    task automatic wr(input logic [6:0] adr, input logic [31:0] d,
                      input logic [3:0] be = 4'hF);
        logic [31:0] dummy;
        xfer(1'b1, adr, be, d, dummy);
    endtask

    task automatic rd(input logic [6:0] adr, output logic [31:0] d);
        xfer(1'b0, adr, 4'hF, 32'h0, d);
    endtask

    initial begin
        up_seq = '{32'd3, 32'd4, 32'd5, 32'd2, 32'd3, 32'd4, 32'd5};
        os_seq = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        dn_seq = '{32'hFFFF, 32'hFFFE, 32'hFFFD};
        WB_RST_N = 1'b0; WBs_ADR = '0; WBs_CYC = 1'b0; WBs_STB = 1'b0;
        WBs_WE = 1'b0; WBs_BYTE_STB = '0; WBs_WR_DAT = '0;
        step(3);
        chk("rst_count_lo", count[31:0], 32'h0);
        chk("rst_count_hi", count[63:32], 32'h0);
        chk("rst_ack", 32'(WBs_ACK), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdat", WBs_RD_DAT, 32'h0);
        WB_RST_N = 1'b1;
        step(1);

        rd(7'h7F, r); chk("id", r, 32'h0000_0C47);
        rd(7'h7E, r); chk("status_init", r, 32'h0);
        rd(7'h40, r); chk("unmapped_rd", r, 32'hBADFABAC);

        // ch0 up-count with reload
        wr(7'd1, 32'd2);
        wr(7'd3, 32'd5);
        wr(7'd0, 32'h1);
        for (int i = 0; i < 7; i++) begin
            chk("ch0_up_seq", cnt(0), up_seq[i]);
            step(1);
        end
        rd(7'h7E, r); chk("ch0_status", r, 32'h1);
        chk("ch0_irq_masked", 32'(irq), 32'd0);
        wr(7'd0, 32'h0);
        wr(7'h7E, 32'h1);
        rd(7'h7E, r); chk("status_w1c", r, 32'h0);

        // ch1 one-shot down with interrupt
        wr(7'd5, 32'd3);
        chk("ch1_load", cnt(1), 32'd3);
        wr(7'd7, 32'd0);
        wr(7'd4, 32'hF);
        for (int i = 0; i < 5; i++) begin
            chk("ch1_os_seq", cnt(1), os_seq[i]);
            step(1);
        end
        chk("ch1_irq", 32'(irq), 32'd1);
        rd(7'd4, r); chk("ch1_ctrl_autoclr", r, 32'hE);
        rd(7'h7E, r); chk("ch1_status", r, 32'h2);
        wr(7'h7E, 32'h2);
        chk("ch1_irq_clr", 32'(irq), 32'd0);

        // ch2 down-count wrap through zero
        wr(7'd9, 32'd0);
        wr(7'd11, 32'h8000);
        chk("ch2_load0", cnt(2), 32'd0);
        wr(7'd8, 32'h3);
        for (int i = 0; i < 3; i++) begin
            chk("ch2_wrap_seq", cnt(2), dn_seq[i]);
            step(1);
        end
        wr(7'd8, 32'h0);

        // terminal beats same-cycle W1C on ch0
        wr(7'd1, 32'd2);
        wr(7'd0, 32'h1);
        chk("sim_pre3", cnt(0), 32'd3);
        step(2);
        chk("sim_pre5", cnt(0), 32'd5);
        wr(7'h7E, 32'h1);
        chk("sim_reload", cnt(0), 32'd3);
        rd(7'h7E, r); chk("sim_w1c_vs_term", r, 32'h1);

        // LOAD write beats terminal on ch0
        wr(7'd0, 32'h0);
        wr(7'h7E, 32'h1);
        rd(7'h7E, r); chk("ld_status_clr", r, 32'h0);
        wr(7'd1, 32'd4);
        wr(7'd0, 32'h1);
        chk("ld_at_cmp", cnt(0), 32'd5);
        wr(7'd1, 32'h10);
        chk("ld_wins", cnt(0), 32'h11);
        rd(7'h7E, r); chk("ld_no_status", r, 32'h0);

        // byte strobes, read-only and unmapped writes on ch3
        wr(7'd13, 32'h1234);
        wr(7'd13, 32'hFFFF, 4'b0001);
        chk("be_count", cnt(3), 32'h12FF);
        rd(7'd13, r); chk("be_load", r, 32'h12FF);
        wr(7'd14, 32'hAAAA);
        rd(7'd14, r); chk("value_ro", r, 32'h12FF);
        wr(7'd15, 32'hFFFF_FFFF);
        rd(7'd15, r); chk("cmp_width", r, 32'h0000_FFFF);
        wr(7'h40, 32'h5555_5555);
        rd(7'h40, r); chk("unmapped_wr", r, 32'hBADFABAC);
        wr(7'h7F, 32'h0);
        rd(7'h7F, r); chk("id_ro", r, 32'h0000_0C47);

        // async reset mid-count, mid-access, with irq high
        wr(7'd5, 32'd1);
        wr(7'd4, 32'hF);
        step(2);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        WBs_CYC = 1'b1; WBs_STB = 1'b1; WBs_WE = 1'b0;
        WBs_ADR = 7'h7F; WBs_BYTE_STB = 4'hF;
        step(1);
        chk("pre_rst_ack", 32'(WBs_ACK), 32'd1);
        #2 WB_RST_N = 1'b0;
        #1;
        chk("arst_ack", 32'(WBs_ACK), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_count_lo", count[31:0], 32'h0);
        chk("arst_count_hi", count[63:32], 32'h0);
        chk("arst_rdat", WBs_RD_DAT, 32'h0);
        WBs_CYC = 1'b0; WBs_STB = 1'b0;
        step(1);
        WB_RST_N = 1'b1;
        step(1);
        rd(7'h7F, r); chk("post_rst_id", r, 32'h0000_0C47);
        rd(7'h7E, r); chk("post_rst_status", r, 32'h0);
        rd(7'd4, r); chk("post_rst_ctrl1", r, 32'h0);
        chk("post_rst_count", count[31:0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
